// File: rtl/id_ex_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_reg
// Description : Decode-to-execute pipeline register for the pipelined LEGv8
//               core. Captures the decode-stage control word, operands and
//               instruction fields every rising edge and presents them to the
//               execute stage one cycle later. Supports hold (stall), bubble
//               insertion (flush) and carries a valid bit alongside.
//
// Ports       : clk          - single clock, all updates on rising edge
//               reset        - synchronous active-high reset (clears all)
//               stall        - hold current contents
//               flush        - load a bubble (all zeros) on next edge
//               id_*         - decode-stage control, index and data inputs
//               ex_*         - registered copies of the id_* inputs
//
// Parameters  : N            - width of operands, immediate and PC
//
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_reg #(
    parameter int N = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          flush,

    input  logic          id_valid,
    input  logic [1:0]    id_aluop,
    input  logic          id_alusrc,
    input  logic          id_regwrite,
    input  logic          id_memread,
    input  logic          id_memwrite,
    input  logic          id_memtoreg,
    input  logic          id_branch,
    input  logic [10:0]   id_funct,
    input  logic [4:0]    id_rn,
    input  logic [4:0]    id_rm,
    input  logic [4:0]    id_rd,
    input  logic [N-1:0]  id_pc,
    input  logic [N-1:0]  id_rd1,
    input  logic [N-1:0]  id_rd2,
    input  logic [N-1:0]  id_signimm,

    output logic          ex_valid,
    output logic [1:0]    ex_aluop,
    output logic          ex_alusrc,
    output logic          ex_regwrite,
    output logic          ex_memread,
    output logic          ex_memwrite,
    output logic          ex_memtoreg,
    output logic          ex_branch,
    output logic [10:0]   ex_funct,
    output logic [4:0]    ex_rn,
    output logic [4:0]    ex_rm,
    output logic [4:0]    ex_rd,
    output logic [N-1:0]  ex_pc,
    output logic [N-1:0]  ex_rd1,
    output logic [N-1:0]  ex_rd2,
    output logic [N-1:0]  ex_signimm
);

    // Everything travels as one flat word: valid(1) + aluop(2) + six
    // single-bit controls + funct(11) + three register indices(15) + four
    // N-bit data fields.
    localparam int BUS_W = 1 + 2 + 6 + 11 + 15 + 4 * N;

    // A bubble is the all-zero word: no register write, no memory access,
    // and aluop=00 makes the ALU do a harmless add.
    localparam logic [BUS_W-1:0] c_BUBBLE = '0;

    logic [BUS_W-1:0] w_id_bus;
    logic [BUS_W-1:0] w_next;
    logic [BUS_W-1:0] r_ex_bus;

    assign w_id_bus = {id_valid, id_aluop, id_alusrc, id_regwrite,
                       id_memread, id_memwrite, id_memtoreg, id_branch,
                       id_funct, id_rn, id_rm, id_rd,
                       id_pc, id_rd1, id_rd2, id_signimm};

    // Priority flush > stall > load. Reset is handled in the register itself
    // so it wins over everything, including an active stall or flush.
    // Invalid slots are passed through as-is; the decoder already zeroes
    // their controls.
    always_comb begin
        w_next = r_ex_bus;
        if (flush) begin
            w_next = c_BUBBLE;
        end else if (!stall) begin
            w_next = w_id_bus;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_bus <= c_BUBBLE;
        end else begin
            r_ex_bus <= w_next;
        end
    end

    assign {ex_valid, ex_aluop, ex_alusrc, ex_regwrite,
            ex_memread, ex_memwrite, ex_memtoreg, ex_branch,
            ex_funct, ex_rn, ex_rm, ex_rd,
            ex_pc, ex_rd1, ex_rd2, ex_signimm} = r_ex_bus;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_reg
// Description : Self-checking bench for id_ex_reg. A table of stimulus
//               records (controls, input bundle, expected behaviour) is
//               applied cycle by cycle; expected outputs are pushed to a
//               scoreboard queue at drive time and compared one edge later.
//               A randomised phase follows, checked against a priority model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_reg;

    localparam int N = 64;

    typedef struct packed {
        logic          valid;
        logic [1:0]    aluop;
        logic          alusrc;
        logic          regwrite;
        logic          memread;
        logic          memwrite;
        logic          memtoreg;
        logic          branch;
        logic [10:0]   funct;
        logic [4:0]    rn;
        logic [4:0]    rm;
        logic [4:0]    rd;
        logic [N-1:0]  pc;
        logic [N-1:0]  rd1;
        logic [N-1:0]  rd2;
        logic [N-1:0]  signimm;
    } bus_t;

    typedef enum logic [1:0] {K_ZERO, K_LOAD, K_HOLD} kind_t;

    typedef struct {
        string  name;
        logic   rst;
        logic   stl;
        logic   fls;
        kind_t  kind;
        bus_t   in;
    } vec_t;

    logic clk;
    logic reset;
    logic stall;
    logic flush;
    bus_t in_b;
    bus_t act;

    logic          ex_valid;
    logic [1:0]    ex_aluop;
    logic          ex_alusrc;
    logic          ex_regwrite;
    logic          ex_memread;
    logic          ex_memwrite;
    logic          ex_memtoreg;
    logic          ex_branch;
    logic [10:0]   ex_funct;
    logic [4:0]    ex_rn;
    logic [4:0]    ex_rm;
    logic [4:0]    ex_rd;
    logic [N-1:0]  ex_pc;
    logic [N-1:0]  ex_rd1;
    logic [N-1:0]  ex_rd2;
    logic [N-1:0]  ex_signimm;

    int   checks;
    int   errors;
    bus_t exp_q[$];
    bus_t prev_exp;
    vec_t vecs[$];

    id_ex_reg #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .id_valid    (in_b.valid),
        .id_aluop    (in_b.aluop),
        .id_alusrc   (in_b.alusrc),
        .id_regwrite (in_b.regwrite),
        .id_memread  (in_b.memread),
        .id_memwrite (in_b.memwrite),
        .id_memtoreg (in_b.memtoreg),
        .id_branch   (in_b.branch),
        .id_funct    (in_b.funct),
        .id_rn       (in_b.rn),
        .id_rm       (in_b.rm),
        .id_rd       (in_b.rd),
        .id_pc       (in_b.pc),
        .id_rd1      (in_b.rd1),
        .id_rd2      (in_b.rd2),
        .id_signimm  (in_b.signimm),
        .ex_valid    (ex_valid),
        .ex_aluop    (ex_aluop),
        .ex_alusrc   (ex_alusrc),
        .ex_regwrite (ex_regwrite),
        .ex_memread  (ex_memread),
        .ex_memwrite (ex_memwrite),
        .ex_memtoreg (ex_memtoreg),
        .ex_branch   (ex_branch),
        .ex_funct    (ex_funct),
        .ex_rn       (ex_rn),
        .ex_rm       (ex_rm),
        .ex_rd       (ex_rd),
        .ex_pc       (ex_pc),
        .ex_rd1      (ex_rd1),
        .ex_rd2      (ex_rd2),
        .ex_signimm  (ex_signimm)
    );

    assign act = {ex_valid, ex_aluop, ex_alusrc, ex_regwrite, ex_memread,
                  ex_memwrite, ex_memtoreg, ex_branch, ex_funct, ex_rn,
                  ex_rm, ex_rd, ex_pc, ex_rd1, ex_rd2, ex_signimm};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bus_t rnd();
        bus_t b;
        b.valid    = 1'($urandom);
        b.aluop    = 2'($urandom);
        b.alusrc   = 1'($urandom);
        b.regwrite = 1'($urandom);
        b.memread  = 1'($urandom);
        b.memwrite = 1'($urandom);
        b.memtoreg = 1'($urandom);
        b.branch   = 1'($urandom);
        b.funct    = 11'($urandom);
        b.rn       = 5'($urandom);
        b.rm       = 5'($urandom);
        b.rd       = 5'($urandom);
        b.pc       = {$urandom, $urandom};
        b.rd1      = {$urandom, $urandom};
        b.rd2      = {$urandom, $urandom};
        b.signimm  = {$urandom, $urandom};
        return b;
    endfunction

    task automatic add(input string name, input logic r, input logic s,
                       input logic f, input kind_t k, input bus_t b);
        vec_t v;
        v.name = name; v.rst = r; v.stl = s; v.fls = f; v.kind = k; v.in = b;
        vecs.push_back(v);
    endtask

    // Drive one cycle of stimulus, queue the expected result, and compare
    // it with the DUT just after the next rising edge.
    task automatic step(input string name, input logic r, input logic s,
                        input logic f, input bus_t b, input bus_t e);
        bus_t got_exp;
        @(negedge clk);
        reset = r; stall = s; flush = f; in_b = b;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got_exp = exp_q.pop_front();
        checks++;
        if (act !== got_exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, got_exp);
        end
        prev_exp = got_exp;
    endtask

    initial begin
        bus_t b;
        bus_t e;
        logic r, s, f;
        checks = 0;
        errors = 0;
        reset = 1'b1; stall = 1'b1; flush = 1'b1;
        in_b = '0;
        prev_exp = '0;

        // ---------------- table of vectors ----------------
        add("reset0", 1, 1, 1, K_ZERO, rnd());
        add("reset1", 1, 1, 1, K_ZERO, rnd());

        b = rnd();
        b.valid = 1; b.aluop = 2'b10; b.funct = 11'b10001011000;
        b.rd1 = 64'h5; b.rd2 = 64'h7; b.rd = 5'd3; b.regwrite = 1;
        b.alusrc = 0; b.memread = 0; b.memwrite = 0; b.memtoreg = 0;
        b.branch = 0;
        add("load_add", 0, 0, 0, K_LOAD, b);
        add("load_follow", 0, 0, 0, K_LOAD, rnd());

        b = rnd();
        b.valid = 1; b.aluop = 2'b00; b.memread = 1; b.signimm = 64'h8;
        b.alusrc = 1; b.regwrite = 1; b.memtoreg = 1; b.memwrite = 0;
        b.branch = 0; b.funct = 11'b11111000010;
        add("load_ldur", 0, 0, 0, K_LOAD, b);
        add("stall_c1", 0, 1, 0, K_HOLD, rnd());
        add("stall_c2", 0, 1, 0, K_HOLD, rnd());
        add("stall_c3", 0, 1, 0, K_HOLD, rnd());
        add("stall_release", 0, 0, 0, K_LOAD, rnd());

        b = rnd();
        b.valid = 1; b.aluop = 2'b10; b.funct = 11'b11001011000;
        b.regwrite = 1;
        add("load_sub", 0, 0, 0, K_LOAD, b);
        add("flush", 0, 0, 1, K_ZERO, rnd());
        add("flush_again", 0, 0, 1, K_ZERO, rnd());

        b = rnd(); b.valid = 1;
        add("load_pre_cbz", 0, 0, 0, K_LOAD, b);
        b = rnd();
        b.valid = 1; b.aluop = 2'b01; b.branch = 1; b.regwrite = 0;
        add("flush_stall_cbz", 0, 1, 1, K_ZERO, b);

        // Invalid slot with non-zero controls passes through unchanged.
        b = rnd();
        b.valid = 0; b.regwrite = 1; b.memwrite = 1; b.aluop = 2'b11;
        add("load_invalid", 0, 0, 0, K_LOAD, b);
        add("stall_m1", 0, 1, 0, K_HOLD, rnd());
        add("stall_m2", 0, 1, 0, K_HOLD, rnd());
        add("reset_mid_stall", 1, 1, 0, K_ZERO, rnd());
        add("post_reset_load", 0, 0, 0, K_LOAD, rnd());
        add("hold_after_load", 0, 1, 0, K_HOLD, rnd());

        foreach (vecs[i]) begin
            case (vecs[i].kind)
                K_ZERO:  e = '0;
                K_LOAD:  e = vecs[i].in;
                default: e = prev_exp;
            endcase
            step(vecs[i].name, vecs[i].rst, vecs[i].stl, vecs[i].fls,
                 vecs[i].in, e);
        end

        // ---------------- randomised sequence ----------------
        // Long stall runs with occasional flush/reset, checked against the
        // reset > flush > stall > load priority.
        for (int i = 0; i < 300; i++) begin
            r = ($urandom_range(0, 19) == 0);
            f = ($urandom_range(0, 9) == 0);
            s = ($urandom_range(0, 2) != 0);
            b = rnd();
            if (r || f)  e = '0;
            else if (s)  e = prev_exp;
            else         e = b;
            step("random", r, s, f, b, e);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- Decode-to-execute pipeline register for the pipelined LEGv8 core.
- Captures the decode-stage control word, operands and instruction fields on each clock, and presents them to the execute stage.
- Its ex_aluop and ex_funct outputs feed the ALU control decoder directly.
- Supports stall (hold), flush (bubble insertion) and a valid bit, for the hazard unit and branch resolution.

Parameters:
N, 64, datapath width of operands, immediate and PC.

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hold current contents (load-use hazard)
flush  input  1  replace contents with bubble next edge (taken branch / exception)
id_valid  input  1  decode stage holds a real instruction
id_aluop  input  2  ALU operation class from main decoder
id_alusrc  input  1  select immediate as ALU operand B
id_regwrite  input  1  write register file in WB
id_memread  input  1  data memory read
id_memwrite  input  1  data memory write
id_memtoreg  input  1  WB selects memory data
id_branch  input  1  conditional/unconditional branch
id_funct  input  11  instruction bits [31:21]
id_rn  input  5  source register 1 index
id_rm  input  5  source register 2 index
id_rd  input  5  destination register index
id_pc  input  N  PC of the decode-stage instruction
id_rd1  input  N  register file read data 1
id_rd2  input  N  register file read data 2
id_signimm  input  N  sign-extended immediate
ex_valid  output  1  registered id_valid
ex_aluop, ex_alusrc, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch  output  2/1/1/1/1/1/1  registered controls
ex_funct  output  11  registered funct
ex_rn, ex_rm, ex_rd  output  5 each  registered register indices
ex_pc, ex_rd1, ex_rd2, ex_signimm  output  N each  registered data

Behaviour:
- Registered outputs only; latency 1 cycle from id_* to ex_*. No combinational input-to-output path.
- Priority at each rising edge: reset > flush > stall > load.
- Reset (reset=1): every ex_* output is 0, including ex_valid=0 and ex_aluop=2'b00. Reset during stall or flush still clears all outputs.
- Flush (reset=0, flush=1): bubble loaded, regardless of stall.
  - Bubble: ex_valid=0; all control outputs 0 (regwrite, memread, memwrite, memtoreg, branch, alusrc, aluop=00).
  - Bubble: ex_funct, ex_rn, ex_rm, ex_rd, ex_pc, ex_rd1, ex_rd2, ex_signimm = 0.
  - A bubble writes nothing and accesses no memory. aluop=00 makes the ALU perform an add, which is harmless.
- Stall (reset=0, flush=0, stall=1): all ex_* outputs hold their previous values, for any number of consecutive cycles.
- Load (reset=0, flush=0, stall=0): all ex_* outputs take the corresponding id_* values.
- Loading with id_valid=0 does not force controls to zero. The decoder guarantees zero controls for invalid slots; the block passes values through unchanged.
- No arithmetic; widths pass through unchanged. N-width fields sized by the parameter.
- After a stall releases, the first load captures the id_* values present in that cycle. The block holds no buffered copy.
- Single clock domain; no asynchronous behaviour. Outputs are X-free from the first edge with reset=1.

Test Plan:
- Reset: hold reset=1 two cycles with all id_* random and stall=flush=1 -> all ex_* = 0, ex_valid=0.
- Load ADD: id_aluop=10, id_funct=11'b10001011000, id_rd1=64'h5, id_rd2=64'h7, id_rd=5'd3, id_regwrite=1, id_valid=1 -> one edge later the ex_* outputs equal these values; other inputs change next cycle and outputs follow one edge later.
- Stall: load LDUR (aluop=00, memread=1, signimm=64'h8), then stall=1 for 3 cycles while the id_* inputs change -> ex_* stays at LDUR values all 3 cycles; on stall=0 the current id_* values load.
- Flush: with SUB loaded (aluop=10, funct=11'b11001011000, regwrite=1), flush=1 one cycle -> ex_valid=0, all controls 0, ex_aluop=00, all data fields 0.
- Flush+stall: stall=1 and flush=1 on the same edge with CBZ at input (aluop=01, branch=1) -> bubble loaded, not hold.
- Reset mid-stall: stall=1 for 2 cycles, then reset=1 for one edge -> all ex_* = 0. Release reset with stall=0 -> the next edge loads id_* normally.
